alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 13 +
 rtl/alu_rr_arbiter.sv | 18 +
 rtl/alu_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: state encoding, opcode constants and latency lookup for the ALU sequencer.
package alu_sequencer_pkg;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    function automatic logic [3:0] op_latency(
        input logic [4:0] op,
        input logic [3:0] mul_lat,
        input logic [3:0] div_lat
    );
        return op == OP_MUL ? mul_lat : op == OP_DIV ? div_lat : 4'd1;
    endfunction
endpackage

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: 2-way round-robin grant; pointer remembers the last granted requester.
module alu_rr_arbiter (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);
    logic last_q;
    assign gnt_id_o = req_i == 2'b11 ? ~last_q : req_i[1];
    assign gnt_o    = req_i == 2'b00 ? 2'b00 : gnt_id_o ? 2'b10 : 2'b01;
    // Pointer starts at 1 so requester 0 wins the first contended round.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) last_q <= 1'b1;
        else if (en_i && |req_i) last_q <= gnt_id_o;
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: arbitrates two requesters onto a shared external ALU and
// returns each result through a valid/ready response port.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_bf,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_bf,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    output logic        alu_bf,
    input  logic [63:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        busy
);
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [4:0]  op_q;
    logic [31:0] a_q, b_q, lo_q, hi_q;
    logic        bf_q, id_q;
    logic        idle, gnt_id;
    logic [1:0]  gnt;
    logic [4:0]  op_d;
    logic [31:0] a_d, b_d;
    logic        bf_d;
    logic [3:0]  lat_d;

    alu_rr_arbiter u_arb (
        .clk      (clk),
        .clr      (clr),
        .req_i    ({req1_valid, req0_valid}),
        .en_i     (idle),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign idle       = state_q == S_IDLE;
    assign req0_ready = gnt[0] & idle & clr;
    assign req1_ready = gnt[1] & idle & clr;
    assign op_d       = gnt_id ? req1_op : req0_op;
    assign a_d        = gnt_id ? req1_a : req0_a;
    assign b_d        = gnt_id ? req1_b : req0_b;
    assign bf_d       = gnt_id ? req1_bf : req0_bf;
    assign lat_d      = op_latency(op_d, 4'(MUL_LAT), 4'(DIV_LAT));

    assign alu_a     = idle ? '0 : a_q;
    assign alu_b     = idle ? '0 : b_q;
    assign alu_op    = idle ? '0 : op_q;
    assign alu_bf    = idle ? 1'b0 : bf_q;
    assign rsp_valid = state_q == S_DONE;
    assign rsp_id    = id_q;
    assign rsp_lo    = lo_q;
    assign rsp_hi    = hi_q;
    assign busy      = !idle;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bf_q    <= 1'b0;
            id_q    <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req0_valid || req1_valid) begin
                    op_q    <= op_d;
                    a_q     <= a_d;
                    b_q     <= b_d;
                    bf_q    <= bf_d;
                    id_q    <= gnt_id;
                    cnt_q   <= lat_d - 4'd1;
                    state_q <= S_EXEC;
                end
                S_EXEC: if (cnt_q == '0) begin
                    lo_q    <= alu_out[31:0];
                    hi_q    <= alu_out[63:32];
                    state_q <= S_DONE;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                S_DONE: if (rsp_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
